shift_seq: RTL and testbench

- Command sequencer directly upstream of the 4-bit bidirectional universal shift register.
- Accepts one command per valid/ready handshake (serial shift-in left/right, parallel load, or timed hold).
- Drives the register's mode selects {s0,s1}, serial inputs ds0/ds3, output enables and the parallel bus, one control vector per clock.
- Same clock as the register; the register acts on the control vector at the same posedge that ends each sequencer cycle.

---
 rtl/shift_seq_pkg.sv | 25 ++
 rtl/shift_seq_if.sv | 31 +++
 rtl/shift_seq_cnt.sv | 48 ++++
 rtl/shift_seq.sv | 200 ++++++++++++++++++++
 tb/tb_shift_seq.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift_seq command sequencer: command opcodes,
// downstream register mode codes ({s0,s1}) and the FSM state type.
package shift_seq_pkg;

  // Command opcodes carried on cmd_op.
  localparam logic [1:0] OP_HOLD    = 2'b00;
  localparam logic [1:0] OP_SHIFT_L = 2'b01;
  localparam logic [1:0] OP_SHIFT_R = 2'b10;
  localparam logic [1:0] OP_LOAD    = 2'b11;

  // Register mode select codes, packed as {s0,s1}.
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StHold,
    StShift,
    StLoad,
    StDone
  } state_e;

endpackage

// File: rtl/shift_seq_if.sv
// Command channel of the shift_seq sequencer: valid/ready handshake plus the
// opcode, length and data fields. The master issues commands, the slave
// (the sequencer) accepts them.
interface shift_seq_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 5
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_len,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_len,
    input  cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/shift_seq_cnt.sv
// Loadable downcounter for shift_seq. Tracks the remaining active cycles of a
// HOLD/SHIFT command, flags the last one, and produces the serial bit index
// for the cycle that starts at the coming clock edge (look-ahead, so the
// sequencer can register the bit together with the rest of the control vector).
module shift_seq_cnt #(
  parameter int unsigned LEN_W = 5
) (
  input  logic             clk_i,
  input  logic             mr_i,
  input  logic             load_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             dec_i,
  input  logic             msb_first_i,
  output logic             last_o,
  output logic [LEN_W-1:0] idx_o
);

  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;

  // Next count: load on accept, otherwise step down but never below 1.
  always_comb begin
    cnt_d = cnt_q;
    len_d = len_q;
    if (load_i) begin
      cnt_d = len_i;
      len_d = len_i;
    end else if (dec_i && (cnt_q > LEN_W'(1))) begin
      cnt_d = cnt_q - LEN_W'(1);
    end
  end

  // Count and latched length registers, synchronous reset.
  always_ff @(posedge clk_i) begin
    if (mr_i) begin
      cnt_q <= '0;
      len_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      len_q <= len_d;
    end
  end

  // MSB-first walks len-1 down to 0; LSB-first walks 0 up to len-1.
  assign idx_o  = msb_first_i ? (cnt_d - LEN_W'(1)) : (len_d - cnt_d);
  assign last_o = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/shift_seq.sv
// Command sequencer driving a 4-bit universal shift register. One command per
// handshake; emits one registered control vector per clock.
// Optional abort support is compiled in with `define SHIFT_SEQ_ABORT_EN.
module shift_seq
  import shift_seq_pkg::*;
#(
  parameter int unsigned REG_W  = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 5
) (
  input  logic             clk,
  input  logic             mr,
  shift_seq_if.slave       cmd,
  output logic             s0,
  output logic             s1,
  output logic             ds0,
  output logic             ds3,
  output logic             oe_n,
  output logic [REG_W-1:0] pdata,
  output logic             pdata_en,
  output logic             busy,
  output logic             done
`ifdef SHIFT_SEQ_ABORT_EN
  ,
  input  logic             cmd_abort,
  output logic             aborted
`endif
);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        mode_q, mode_d;
  logic              ds0_q, ds0_d, ds3_q, ds3_d;
  logic              oe_n_q, oe_n_d;
  logic [REG_W-1:0]  pdata_q, pdata_d;
  logic              pdata_en_q, pdata_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic             accept;
  logic [LEN_W-1:0] len_eff;
  logic             cnt_load, cnt_dec, cnt_last;
  logic [LEN_W-1:0] cnt_idx;
  logic             ser_bit;
  logic             abort_hit;

  assign cmd.cmd_ready = (state_q == StIdle) && !mr;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign len_eff       = (cmd.cmd_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : cmd.cmd_len;

`ifdef SHIFT_SEQ_ABORT_EN
  assign abort_hit = cmd_abort && ((state_q == StHold) || (state_q == StShift));
`else
  assign abort_hit = 1'b0;
`endif

  // Serial bit for the upcoming cycle, picked from the (possibly just latched) data.
  assign ser_bit = |(data_d & (DATA_W'(1) << cnt_idx));

  shift_seq_cnt #(
    .LEN_W(LEN_W)
  ) u_cnt (
    .clk_i       (clk),
    .mr_i        (mr),
    .load_i      (cnt_load),
    .len_i       (len_eff),
    .dec_i       (cnt_dec),
    .msb_first_i (op_d == OP_SHIFT_L),
    .last_o      (cnt_last),
    .idx_o       (cnt_idx)
  );

  // Next state, then the control vector belonging to that next state.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    mode_d     = MODE_HOLD;
    ds0_d      = 1'b0;
    ds3_d      = 1'b0;
    oe_n_d     = 1'b0;
    pdata_d    = '0;
    pdata_en_d = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          op_d     = cmd.cmd_op;
          data_d   = cmd.cmd_data;
          cnt_load = 1'b1;
          if (cmd.cmd_op == OP_LOAD) begin
            state_d = StLoad;
          end else if (len_eff == '0) begin
            state_d = StDone;
          end else if (cmd.cmd_op == OP_HOLD) begin
            state_d = StHold;
          end else begin
            state_d = StShift;
          end
        end
      end
      StHold, StShift: begin
        if (abort_hit || cnt_last) begin
          state_d = StDone;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StLoad:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    case (state_d)
      StShift: begin
        if (op_d == OP_SHIFT_L) begin
          mode_d = MODE_SHL;
          ds0_d  = ser_bit;
        end else begin
          mode_d = MODE_SHR;
          ds3_d  = ser_bit;
        end
      end
      StLoad: begin
        mode_d     = MODE_LOAD;
        oe_n_d     = 1'b1;
        pdata_en_d = 1'b1;
        pdata_d    = data_d[REG_W-1:0];
      end
      StDone: begin
        done_d = 1'b1;
        // Bus turnaround: keep the register off the bus one more cycle after LOAD.
        oe_n_d = (state_q == StLoad);
      end
      default: ;
    endcase
  end

  assign busy_d = (state_d != StIdle);

  // State, latched command and registered control outputs.
  always_ff @(posedge clk) begin
    if (mr) begin
      state_q    <= StIdle;
      op_q       <= OP_HOLD;
      data_q     <= '0;
      mode_q     <= MODE_HOLD;
      ds0_q      <= 1'b0;
      ds3_q      <= 1'b0;
      oe_n_q     <= 1'b0;
      pdata_q    <= '0;
      pdata_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      data_q     <= data_d;
      mode_q     <= mode_d;
      ds0_q      <= ds0_d;
      ds3_q      <= ds3_d;
      oe_n_q     <= oe_n_d;
      pdata_q    <= pdata_d;
      pdata_en_q <= pdata_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef SHIFT_SEQ_ABORT_EN
  logic aborted_q;

  // Abort flag rides with the done pulse it causes.
  always_ff @(posedge clk) begin
    if (mr) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= abort_hit;
    end
  end

  assign aborted = aborted_q;
`endif

  // An abort turns the current cycle into a hold, so no further bit is applied.
  assign s0       = mode_q[1] & ~abort_hit;
  assign s1       = mode_q[0] & ~abort_hit;
  assign ds0      = ds0_q & ~abort_hit;
  assign ds3      = ds3_q & ~abort_hit;
  assign oe_n     = oe_n_q;
  assign pdata    = pdata_q;
  assign pdata_en = pdata_en_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: directed boundary cases plus random
// commands, checked cycle by cycle against a per-command expected trace and
// a behavioural model of the downstream 4-bit shift register.
module tb_shift_seq;
  import shift_seq_pkg::*;

  localparam int REG_W  = 4;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 5;

  logic clk = 1'b0;
  logic mr;
  always #5 clk = ~clk;

  shift_seq_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) cmd_bus ();

  logic             s0, s1, ds0, ds3, oe_n, pdata_en, busy, done;
  logic [REG_W-1:0] pdata;
`ifdef SHIFT_SEQ_ABORT_EN
  logic cmd_abort, aborted;
`endif

  shift_seq #(
    .REG_W (REG_W),
    .DATA_W(DATA_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk     (clk),
    .mr      (mr),
    .cmd     (cmd_bus.slave),
    .s0      (s0),
    .s1      (s1),
    .ds0     (ds0),
    .ds3     (ds3),
    .oe_n    (oe_n),
    .pdata   (pdata),
    .pdata_en(pdata_en),
    .busy    (busy),
    .done    (done)
`ifdef SHIFT_SEQ_ABORT_EN
    ,
    .cmd_abort(cmd_abort),
    .aborted  (aborted)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Downstream universal shift register, driven by the DUT's control vector.
  logic [3:0] reg_q;
  logic       reg_clr;
  always @(posedge clk) begin
    if (reg_clr) reg_q <= 4'h0;
    else begin
      case ({s0, s1})
        2'b01:   reg_q <= {reg_q[2:0], ds0};
        2'b10:   reg_q <= {ds3, reg_q[3:1]};
        2'b11:   if (pdata_en) reg_q <= pdata;
        default: ;
      endcase
    end
  end

  logic [3:0] q_exp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Register contents after n shift/hold steps, derived arithmetically.
  task automatic model_apply(input logic [1:0] op, input int n, input logic [15:0] data);
    longint unsigned d;
    d = longint'(data) & ((64'd1 << n) - 64'd1);
    case (op)
      OP_SHIFT_L: q_exp = 4'((longint'(q_exp) << n) | d);
      OP_SHIFT_R: q_exp = 4'(((d << 4) | longint'(q_exp)) >> n);
      OP_LOAD:    q_exp = data[3:0];
      default:    ;
    endcase
  endtask

  task automatic clr_reg();
    @(negedge clk);
    reg_clr = 1'b1;
    @(negedge clk);
    reg_clr = 1'b0;
    q_exp   = 4'h0;
  endtask

  // Waits (bounded) for ready, presents the command, and lets it be accepted.
  task automatic issue(input logic [1:0] op, input int len, input logic [15:0] data,
                       input bit keep);
    int k = 0;
    @(negedge clk);
    while (!cmd_bus.cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("ready_timeout", 32'(cmd_bus.cmd_ready), 32'd1);
    cmd_bus.cmd_op    = op;
    cmd_bus.cmd_len   = LEN_W'(len);
    cmd_bus.cmd_data  = data;
    cmd_bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!keep) cmd_bus.cmd_valid = 1'b0;
  endtask

  // Checks every cycle after acceptance up to and including the idle cycle.
  task automatic trace(input logic [1:0] op, input int len, input logic [15:0] data);
    int         n, act;
    logic [1:0] mode;
    logic       ld;
    n   = (len > DATA_W) ? DATA_W : len;
    ld  = (op == OP_LOAD);
    act = ld ? 1 : n;
    case (op)
      OP_SHIFT_L: mode = 2'b01;
      OP_SHIFT_R: mode = 2'b10;
      OP_LOAD:    mode = 2'b11;
      default:    mode = 2'b00;
    endcase
    for (int i = 0; i < act; i++) begin
      @(negedge clk);
      chk("active_ctl", 32'({s0, s1, oe_n, pdata_en, busy, done}),
          32'({mode, ld, ld, 1'b1, 1'b0}));
      if (op == OP_SHIFT_L) chk("ds_shl", 32'({ds0, ds3}), 32'({data[n-1-i], 1'b0}));
      if (op == OP_SHIFT_R) chk("ds_shr", 32'({ds0, ds3}), 32'({1'b0, data[i]}));
      if (ld) chk("pdata", 32'(pdata), 32'(data[3:0]));
    end
    @(negedge clk);
    chk("done_ctl", 32'({s0, s1, oe_n, pdata_en, busy, done}),
        32'({2'b00, ld, 1'b0, 1'b1, 1'b1}));
`ifdef SHIFT_SEQ_ABORT_EN
    chk("aborted_clear", 32'(aborted), 32'd0);
`endif
    @(negedge clk);
    chk("idle_ctl", 32'({s0, s1, oe_n, pdata_en, busy, done, cmd_bus.cmd_ready}),
        32'(7'b0000001));
    model_apply(op, n, data);
    chk("reg_q", 32'(reg_q), 32'(q_exp));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [15:0] d;
    logic [1:0]  op;
    int          len;

    mr                = 1'b1;
    reg_clr           = 1'b1;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_op    = 2'b00;
    cmd_bus.cmd_len   = '0;
    cmd_bus.cmd_data  = '0;
`ifdef SHIFT_SEQ_ABORT_EN
    cmd_abort = 1'b0;
`endif
    q_exp = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 32'({s0, s1, ds0, ds3, oe_n, pdata_en, busy, done, pdata}), 32'd0);
    chk("ready_in_reset", 32'(cmd_bus.cmd_ready), 32'd0);
    mr      = 1'b0;
    reg_clr = 1'b0;
    #1;
    chk("ready_after_reset", 32'(cmd_bus.cmd_ready), 32'd1);

    // Directed cases.
    issue(OP_SHIFT_L, 4, 16'h000B, 1'b0);
    trace(OP_SHIFT_L, 4, 16'h000B);
    clr_reg();
    issue(OP_SHIFT_R, 4, 16'h000B, 1'b0);
    trace(OP_SHIFT_R, 4, 16'h000B);
    issue(OP_LOAD, 9, 16'h0006, 1'b0);
    trace(OP_LOAD, 9, 16'h0006);
    issue(OP_SHIFT_L, 0, 16'hFFFF, 1'b0);
    trace(OP_SHIFT_L, 0, 16'hFFFF);
    issue(OP_HOLD, 31, 16'h1234, 1'b0);
    trace(OP_HOLD, 31, 16'h1234);

    // Valid held through busy: the second command goes in right after done.
    issue(OP_SHIFT_R, 5, 16'h0015, 1'b1);
    cmd_bus.cmd_op   = OP_SHIFT_L;
    cmd_bus.cmd_len  = LEN_W'(3);
    cmd_bus.cmd_data = 16'h0005;
    trace(OP_SHIFT_R, 5, 16'h0015);
    @(posedge clk);
    #1;
    cmd_bus.cmd_valid = 1'b0;
    trace(OP_SHIFT_L, 3, 16'h0005);

    // Reset in the middle of a shift abandons it without a done pulse.
    issue(OP_SHIFT_L, 8, 16'h00A5, 1'b0);
    repeat (3) @(negedge clk);
    mr = 1'b1;
    @(negedge clk);
    chk("midreset_outs", 32'({s0, s1, ds0, ds3, oe_n, pdata_en, busy, done, pdata}), 32'd0);
    chk("midreset_ready", 32'(cmd_bus.cmd_ready), 32'd0);
    @(negedge clk);
    chk("midreset_nodone", 32'({busy, done}), 32'd0);
    mr = 1'b0;
    #1;
    chk("midreset_ready_rel", 32'(cmd_bus.cmd_ready), 32'd1);
    clr_reg();

    // Random commands.
    for (int t = 0; t < 24; t++) begin
      op  = 2'($urandom_range(0, 3));
      len = $urandom_range(0, 31);
      d   = 16'($urandom);
      issue(op, len, d, 1'b0);
      trace(op, len, d);
    end

`ifdef SHIFT_SEQ_ABORT_EN
    clr_reg();
    d = 16'($urandom);
    issue(OP_SHIFT_R, 8, d, 1'b0);
    repeat (2) @(negedge clk);
    @(negedge clk);
    cmd_abort = 1'b1;
    #1;
    chk("abort_mode", 32'({s0, s1}), 32'd0);
    @(posedge clk);
    #1;
    cmd_abort = 1'b0;
    @(negedge clk);
    chk("abort_done", 32'({busy, done, aborted}), 32'(3'b111));
    @(negedge clk);
    chk("abort_idle", 32'({busy, done, aborted, cmd_bus.cmd_ready}), 32'(4'b0001));
    model_apply(OP_SHIFT_R, 2, d);
    chk("abort_reg_q", 32'(reg_q), 32'(q_exp));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
